// File: rtl/xil_7s_dphy_hs_clk_tx_if.sv
// Handshake and pin bundle between the HS clock-lane controller, the data lanes and the IO buffers.
// The controller sits on the master modport; the data lanes and the bench sit on the slave modport.
interface xil_7s_dphy_hs_clk_tx_if;
  logic       hs_req_i;
  logic       hs_clk_ready_o;
  logic       busy_o;
  logic       lp_p_o;
  logic       lp_n_o;
  logic       hs_oe_o;
  logic [7:0] hs_data_o;

  modport master (
    input  hs_req_i,
    output hs_clk_ready_o,
    output busy_o,
    output lp_p_o,
    output lp_n_o,
    output hs_oe_o,
    output hs_data_o
  );

  modport slave (
    output hs_req_i,
    input  hs_clk_ready_o,
    input  busy_o,
    input  lp_p_o,
    input  lp_n_o,
    input  hs_oe_o,
    input  hs_data_o
  );
endinterface

// File: rtl/xil_7s_dphy_hs_clk_tx.sv
// D-PHY clock-lane TX sequencer in the byte clock domain: LP-11 -> LP-01 -> LP-00 -> HS-0 ->
// HS toggling -> HS trail -> LP-11, driving the LP buffers and an 8:1 OSERDESE2.
module xil_7s_dphy_hs_clk_tx #(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned T_LPX         = 2,
  parameter int unsigned T_CLK_PREPARE = 3,
  parameter int unsigned T_CLK_ZERO    = 12,
  parameter int unsigned T_CLK_PRE     = 2,
  parameter int unsigned T_CLK_POST    = 6,
  parameter int unsigned T_CLK_TRAIL   = 3,
  parameter int unsigned T_HS_EXIT     = 4,
  parameter logic [7:0]  CLK_PATTERN   = 8'h55
) (
  input logic                     clk_i,
  input logic                     rst_i,
  xil_7s_dphy_hs_clk_tx_if.master bus
);

  localparam longint unsigned TMax = 64'd1 << CNT_W;

  if (T_LPX < 1 || T_CLK_PREPARE < 1 || T_CLK_ZERO < 1 || T_CLK_PRE < 1 ||
      T_CLK_POST < 1 || T_CLK_TRAIL < 1 || T_HS_EXIT < 1 ||
      longint'(T_LPX) > TMax || longint'(T_CLK_PREPARE) > TMax ||
      longint'(T_CLK_ZERO) > TMax || longint'(T_CLK_PRE) > TMax ||
      longint'(T_CLK_POST) > TMax || longint'(T_CLK_TRAIL) > TMax ||
      longint'(T_HS_EXIT) > TMax) begin : g_bad_timing
    $error("xil_7s_dphy_hs_clk_tx: every T_x must be in 1..2**CNT_W");
  end

  // Counter loads T_x-1 on entry so each timed state lasts exactly T_x cycles.
  localparam logic [CNT_W-1:0] LdLpx     = CNT_W'(T_LPX - 1);
  localparam logic [CNT_W-1:0] LdPrepare = CNT_W'(T_CLK_PREPARE - 1);
  localparam logic [CNT_W-1:0] LdZero    = CNT_W'(T_CLK_ZERO - 1);
  localparam logic [CNT_W-1:0] LdPre     = CNT_W'(T_CLK_PRE - 1);
  localparam logic [CNT_W-1:0] LdPost    = CNT_W'(T_CLK_POST - 1);
  localparam logic [CNT_W-1:0] LdTrail   = CNT_W'(T_CLK_TRAIL - 1);
  localparam logic [CNT_W-1:0] LdExit    = CNT_W'(T_HS_EXIT - 1);

  typedef enum logic [3:0] {
    StIdle,
    StLp01,
    StLp00,
    StHsZero,
    StHsPre,
    StHsActive,
    StHsPost,
    StHsTrail,
    StHsExit
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lp_p_q, lp_p_d;
  logic             lp_n_q, lp_n_d;
  logic             hs_oe_q, hs_oe_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             timeout;

  assign timeout = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.hs_req_i) begin
          state_d = StLp01;
          cnt_d   = LdLpx;
        end
      end
      StLp01: begin
        if (timeout) begin
          state_d = StLp00;
          cnt_d   = LdPrepare;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StLp00: begin
        if (timeout) begin
          state_d = StHsZero;
          cnt_d   = LdZero;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHsZero: begin
        if (timeout) begin
          state_d = StHsPre;
          cnt_d   = LdPre;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHsPre: begin
        if (timeout) begin
          state_d = StHsActive;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHsActive: begin
        if (!bus.hs_req_i) begin
          state_d = StHsPost;
          cnt_d   = LdPost;
        end
      end
      StHsPost: begin
        if (timeout) begin
          state_d = StHsTrail;
          cnt_d   = LdTrail;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHsTrail: begin
        if (timeout) begin
          state_d = StHsExit;
          cnt_d   = LdExit;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHsExit: begin
        if (timeout) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the next state so pins switch on the same edge as the state register.
  always_comb begin
    lp_p_d  = 1'b0;
    lp_n_d  = 1'b0;
    hs_oe_d = 1'b0;
    data_d  = 8'h00;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    unique case (state_d)
      StIdle: begin
        lp_p_d = 1'b1;
        lp_n_d = 1'b1;
        busy_d = 1'b0;
      end
      StLp01:   lp_n_d = 1'b1;
      StLp00:   ;
      StHsZero: hs_oe_d = 1'b1;
      StHsPre: begin
        hs_oe_d = 1'b1;
        data_d  = CLK_PATTERN;
      end
      StHsActive: begin
        hs_oe_d = 1'b1;
        data_d  = CLK_PATTERN;
        ready_d = 1'b1;
      end
      StHsPost: begin
        hs_oe_d = 1'b1;
        data_d  = CLK_PATTERN;
      end
      StHsTrail: hs_oe_d = 1'b1;
      StHsExit: begin
        lp_p_d = 1'b1;
        lp_n_d = 1'b1;
      end
      default: begin
        lp_p_d = 1'b1;
        lp_n_d = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lp_p_q  <= 1'b1;
      lp_n_q  <= 1'b1;
      hs_oe_q <= 1'b0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lp_p_q  <= lp_p_d;
      lp_n_q  <= lp_n_d;
      hs_oe_q <= hs_oe_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.lp_p_o         = lp_p_q;
  assign bus.lp_n_o         = lp_n_q;
  assign bus.hs_oe_o        = hs_oe_q;
  assign bus.hs_data_o      = data_q;
  assign bus.hs_clk_ready_o = ready_q;
  assign bus.busy_o         = busy_q;

endmodule

// File: tb/tb_xil_7s_dphy_hs_clk_tx.sv
// Directed bench for the clock-lane TX sequencer: default timing on one instance, all-T=1 timing
// with random requests on a second instance.
module tb_xil_7s_dphy_hs_clk_tx;

  localparam int SIdle = 0, SLp01 = 1, SLp00 = 2, SZero = 3, SPre = 4;
  localparam int SActive = 5, SPost = 6, STrail = 7, SExit = 8;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  xil_7s_dphy_hs_clk_tx_if bus0 ();
  xil_7s_dphy_hs_clk_tx_if bus1 ();

  xil_7s_dphy_hs_clk_tx dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus0)
  );

  xil_7s_dphy_hs_clk_tx #(
    .T_LPX         (1),
    .T_CLK_PREPARE (1),
    .T_CLK_ZERO    (1),
    .T_CLK_PRE     (1),
    .T_CLK_POST    (1),
    .T_CLK_TRAIL   (1),
    .T_HS_EXIT     (1)
  ) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  // {ready, busy, lp_p, lp_n, hs_oe, data}
  logic [12:0] obs0, obs1;
  assign obs0 = {bus0.hs_clk_ready_o, bus0.busy_o, bus0.lp_p_o, bus0.lp_n_o, bus0.hs_oe_o,
                 bus0.hs_data_o};
  assign obs1 = {bus1.hs_clk_ready_o, bus1.busy_o, bus1.lp_p_o, bus1.lp_n_o, bus1.hs_oe_o,
                 bus1.hs_data_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] exp_out(input int code);
    case (code)
      SIdle:   return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
      SLp01:   return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
      SLp00:   return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      SZero:   return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
      SPre:    return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55};
      SActive: return {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55};
      SPost:   return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55};
      STrail:  return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
      SExit:   return {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
      default: return 13'h1fff;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges on dut0, checking the output vector after each.
  task automatic expect_run(input string tag, input int code, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, 32'(obs0), 32'(exp_out(code)));
    end
  endtask

  function automatic int model_next(input int m, input logic req);
    case (m)
      SIdle:   return req ? SLp01 : SIdle;
      SActive: return req ? SActive : SPost;
      SExit:   return SIdle;
      default: return m + 1;
    endcase
  endfunction

  initial begin
    int m;
    int m_next;
    rst           = 1'b1;
    bus0.hs_req_i = 1'b0;
    bus1.hs_req_i = 1'b0;
    #2;
    check("reset_state", 32'(obs0), 32'(exp_out(SIdle)));
    tick();
    tick();
    rst = 1'b0;
    expect_run("idle_after_reset", SIdle, 2);

    // Full default sequence: request rises after edge 0, drops after edge 30.
    tick();
    bus0.hs_req_i = 1'b1;
    expect_run("startup_lp01", SLp01, 2);
    expect_run("startup_lp00", SLp00, 3);
    expect_run("startup_hs_zero", SZero, 12);
    expect_run("startup_hs_pre", SPre, 2);
    expect_run("active", SActive, 11);
    bus0.hs_req_i = 1'b0;
    expect_run("post", SPost, 6);
    expect_run("trail", STrail, 3);
    expect_run("exit", SExit, 4);
    expect_run("idle_edge44", SIdle, 2);

    // One-cycle request pulse: startup completes, ready for exactly one cycle.
    bus0.hs_req_i = 1'b1;
    expect_run("pulse_lp01", SLp01, 1);
    bus0.hs_req_i = 1'b0;
    expect_run("pulse_lp01", SLp01, 1);
    expect_run("pulse_lp00", SLp00, 3);
    expect_run("pulse_zero", SZero, 12);
    expect_run("pulse_pre", SPre, 2);
    expect_run("pulse_active", SActive, 1);
    expect_run("pulse_post", SPost, 6);
    expect_run("pulse_trail", STrail, 3);
    expect_run("pulse_exit", SExit, 4);
    expect_run("pulse_idle", SIdle, 2);

    // Request reasserted during the trail and held: single IDLE cycle, then LP01.
    bus0.hs_req_i = 1'b1;
    expect_run("re_lp01", SLp01, 2);
    expect_run("re_lp00", SLp00, 3);
    expect_run("re_zero", SZero, 12);
    expect_run("re_pre", SPre, 2);
    expect_run("re_active", SActive, 3);
    bus0.hs_req_i = 1'b0;
    expect_run("re_post", SPost, 6);
    expect_run("re_trail", STrail, 1);
    bus0.hs_req_i = 1'b1;
    expect_run("re_trail_held", STrail, 2);
    expect_run("re_exit_held", SExit, 4);
    expect_run("re_idle_once", SIdle, 1);
    expect_run("re_lp01_again", SLp01, 2);
    expect_run("re_lp00_again", SLp00, 3);
    expect_run("re_zero_again", SZero, 12);
    expect_run("re_pre_again", SPre, 2);
    expect_run("re_active_again", SActive, 2);

    // Asynchronous reset between edges while HS is running.
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_out", 32'(obs0), 32'(exp_out(SIdle)));
    bus0.hs_req_i = 1'b0;
    tick();
    check("reset_held", 32'(obs0), 32'(exp_out(SIdle)));
    rst = 1'b0;
    expect_run("post_reset_idle", SIdle, 3);
    bus0.hs_req_i = 1'b1;
    expect_run("post_reset_lp01", SLp01, 1);
    bus0.hs_req_i = 1'b0;
    expect_run("post_reset_lp01", SLp01, 1);
    expect_run("post_reset_lp00", SLp00, 3);
    expect_run("post_reset_zero", SZero, 12);
    expect_run("post_reset_pre", SPre, 2);
    expect_run("post_reset_active", SActive, 1);
    expect_run("post_reset_post", SPost, 6);
    expect_run("post_reset_trail", STrail, 3);
    expect_run("post_reset_exit", SExit, 4);
    expect_run("post_reset_idle2", SIdle, 1);

    // All T_x = 1 instance with random requests against a one-cycle-per-state model.
    m = SIdle;
    check("t1_start_idle", 32'(obs1), 32'(exp_out(SIdle)));
    for (int i = 0; i < 300; i++) begin
      bus1.hs_req_i = 1'($urandom_range(0, 1));
      m_next = model_next(m, bus1.hs_req_i);
      tick();
      m = m_next;
      check("t1_seq", 32'(obs1), 32'(exp_out(m)));
      check("t1_lp_while_oe", 32'(bus1.hs_oe_o && (bus1.lp_p_o || bus1.lp_n_o)), 32'd0);
      check("t1_ready_pattern", 32'(bus1.hs_clk_ready_o && (bus1.hs_data_o != 8'h55)), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Invariants on the default-timing instance throughout the run.
  always @(negedge clk) begin
    if (!rst) begin
      check("lp_while_oe", 32'(bus0.hs_oe_o && (bus0.lp_p_o || bus0.lp_n_o)), 32'd0);
      check("ready_pattern", 32'(bus0.hs_clk_ready_o && (bus0.hs_data_o != 8'h55)), 32'd0);
    end
  end

endmodule
